// File: rtl/clk_rate_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk_rate_pkg                                               |
// | Description : Shared types and default sizing for the slow-clock divider |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package clk_rate_pkg;

    localparam int CNT_W        = 28;
    localparam int DEFAULT_HALF = 500000;
    localparam int MIN_HALF     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_half_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk_half_counter                                           |
// | Description : Half-period counter with clear, load-to-1 and terminal flag|
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module clk_half_counter #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_term
);

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= C_ONE;
        end else if (i_inc) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    assign o_term = (r_cnt == i_limit);

endmodule
`default_nettype wire

// File: rtl/clk_rate_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk_rate_ctrl                                              |
// | Description : Reprogrammable 50% slow clock + tick, glitch-free updates  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module clk_rate_ctrl #(
    parameter int CNT_W        = clk_rate_pkg::CNT_W,
    parameter int DEFAULT_HALF = clk_rate_pkg::DEFAULT_HALF,
    parameter int MIN_HALF     = clk_rate_pkg::MIN_HALF
) (
    input  logic             clk100Mhz,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             slow_clk,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] cur_half
);

    import clk_rate_pkg::*;

    localparam logic [CNT_W-1:0] C_DEFAULT = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(MIN_HALF);

    state_t           r_state, w_state_nxt;
    logic             r_slow, r_tick, r_err;
    logic [CNT_W-1:0] r_cur, r_pend;

    logic             w_slow_nxt, w_tick_nxt, w_err_nxt;
    logic [CNT_W-1:0] w_cur_nxt, w_pend_nxt;
    logic             w_cnt_clr, w_cnt_load, w_cnt_inc, w_term;
    logic             w_accept, w_take;

    clk_half_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk100Mhz),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_load  (w_cnt_load),
        .i_inc   (w_cnt_inc),
        .i_limit (r_cur),
        .o_term  (w_term)
    );

    assign cfg_ready = (r_state != PEND);
    assign running   = (r_state != IDLE);
    assign slow_clk  = r_slow;
    assign tick      = r_tick;
    assign cfg_err   = r_err;
    assign cur_half  = r_cur;

    assign w_accept = cfg_valid && cfg_ready;
    assign w_take   = w_accept && (cfg_half >= C_MIN);

    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_slow_nxt  = r_slow;
        w_tick_nxt  = 1'b0;
        w_err_nxt   = w_accept && !w_take;
        w_cur_nxt   = r_cur;
        w_pend_nxt  = r_pend;
        case (r_state)
            IDLE: begin
                w_cnt_clr  = 1'b1;
                w_slow_nxt = 1'b0;
                if (w_take) w_cur_nxt = cfg_half;
                if (en) begin
                    w_state_nxt = RUN;
                    w_cnt_clr   = 1'b0;
                    w_cnt_load  = 1'b1;
                end
            end
            RUN, PEND: begin
                // Only reachable from RUN: cfg_ready is low in PEND.
                if (w_take) begin
                    w_pend_nxt  = cfg_half;
                    w_state_nxt = PEND;
                end
                if (!en && !r_slow) begin
                    // Truncating a low phase is safe; settle any new rate now.
                    w_state_nxt = IDLE;
                    w_cnt_clr   = 1'b1;
                    if (r_state == PEND) w_cur_nxt = r_pend;
                    else if (w_take)     w_cur_nxt = cfg_half;
                end else if (w_term) begin
                    w_cnt_load = 1'b1;
                    w_slow_nxt = !r_slow;
                    w_tick_nxt = !r_slow;
                    if (r_slow) begin
                        if (r_state == PEND) begin
                            w_cur_nxt   = r_pend;
                            w_state_nxt = RUN;
                        end
                        if (!en) begin
                            w_state_nxt = IDLE;
                            w_cnt_load  = 1'b0;
                            w_cnt_clr   = 1'b1;
                            if (r_state == RUN && w_take) w_cur_nxt = cfg_half;
                        end
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_clr   = 1'b1;
                w_slow_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
            r_slow <= 1'b0;
            r_tick <= 1'b0;
            r_err  <= 1'b0;
            r_cur  <= C_DEFAULT;
            r_pend <= '0;
        end else begin
            r_slow <= w_slow_nxt;
            r_tick <= w_tick_nxt;
            r_err  <= w_err_nxt;
            r_cur  <= w_cur_nxt;
            r_pend <= w_pend_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_rate_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_clk_rate_ctrl                                           |
// | Description : Scoreboard bench for clk_rate_ctrl (half=4, min=2, 8 bit)  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_clk_rate_ctrl;

    localparam int CNT_W = 8;
    localparam logic [1:0] K_FALL = 2'd0;
    localparam logic [1:0] K_RISE = 2'd1;
    localparam logic [1:0] K_TICK = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst, en, cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready, cfg_err, slow_clk, tick, running;
    logic [CNT_W-1:0] cur_half;

    logic [31:0] cyc = 0;
    logic        prev_slow = 1'b0;
    int          total = 0;
    int          bad = 0;
    ev_t         exp_q[$];
    ev_t         act_q[$];

    clk_rate_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(4), .MIN_HALF(2)) dut (
        .clk100Mhz (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .slow_clk  (slow_clk),
        .tick      (tick),
        .running   (running),
        .cur_half  (cur_half)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic [1:0] k, input logic [31:0] c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        return e;
    endfunction

    // Edge/tick recorder: stamps each observed event with the posedge count.
    always @(negedge clk) begin
        if (!rst) begin
            if (slow_clk !== prev_slow) act_q.push_back(mk(slow_clk ? K_RISE : K_FALL, cyc));
            if (tick === 1'b1) act_q.push_back(mk(K_TICK, cyc));
        end
        prev_slow = slow_clk;
    end

    task automatic at_cyc(input logic [31:0] n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        en = 1'b0; cfg_valid = 1'b0; cfg_half = '0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic exp_rise(input logic [31:0] c);
        exp_q.push_back(mk(K_RISE, c));
        exp_q.push_back(mk(K_TICK, c));
    endtask

    task automatic test_reset();
        en = 1'b0; cfg_valid = 1'b0; cfg_half = '0; rst = 1'b1;
        @(negedge clk);
        total++; if (slow_clk !== 1'b0) begin bad++; $display("FAIL rst_slow got=%0d exp=0", slow_clk); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%0d exp=0", tick); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0d exp=0", cfg_err); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running got=%0d exp=0", running); end
        total++; if (cur_half !== 8'd4) begin bad++; $display("FAIL rst_cur_half got=%0d exp=4", cur_half); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0d exp=1", cfg_ready); end
        total++; if (slow_clk !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL idle_hold got=%0d/%0d exp=0/0", slow_clk, running); end
    endtask

    task automatic test_run();
        logic [31:0] b;
        ev_t e, a;
        do_reset();
        en = 1'b1; b = cyc + 1;
        exp_rise(b + 4); exp_q.push_back(mk(K_FALL, b + 8));
        exp_rise(b + 12); exp_q.push_back(mk(K_FALL, b + 16));
        at_cyc(b + 2);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL run_running got=%0d exp=1", running); end
        at_cyc(b + 18);
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL run_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL run_event got=%0d@%0d exp=%0d@%0d", a.kind, a.cyc, e.kind, e.cyc); end
        end
    endtask

    task automatic test_reconfig();
        logic [31:0] b;
        ev_t e, a;
        do_reset();
        en = 1'b1; b = cyc + 1;
        exp_rise(b + 4); exp_q.push_back(mk(K_FALL, b + 8));
        exp_rise(b + 10); exp_q.push_back(mk(K_FALL, b + 12));
        exp_rise(b + 14); exp_q.push_back(mk(K_FALL, b + 16));
        at_cyc(b + 5);
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_ready_run got=%0d exp=1", cfg_ready); end
        cfg_valid = 1'b1; cfg_half = 8'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_ready_pend got=%0d exp=0", cfg_ready); end
        at_cyc(b + 7);
        total++; if (cfg_ready !== 1'b0 || cur_half !== 8'd4) begin bad++; $display("FAIL pend_hold got=%0d/%0d exp=0/4", cfg_ready, cur_half); end
        at_cyc(b + 8);
        total++; if (cfg_ready !== 1'b1 || cur_half !== 8'd2) begin bad++; $display("FAIL pend_apply got=%0d/%0d exp=1/2", cfg_ready, cur_half); end
        at_cyc(b + 17);
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL recfg_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL recfg_event got=%0d@%0d exp=%0d@%0d", a.kind, a.cyc, e.kind, e.cyc); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] b;
        ev_t e, a;
        do_reset();
        en = 1'b1; b = cyc + 1;
        exp_rise(b + 4); exp_q.push_back(mk(K_FALL, b + 8));
        exp_rise(b + 12); exp_q.push_back(mk(K_FALL, b + 16));
        at_cyc(b + 5);
        cfg_valid = 1'b1; cfg_half = 8'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%0d exp=1", cfg_err); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL err_ready got=%0d exp=1", cfg_ready); end
        @(negedge clk);
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_width got=%0d exp=0", cfg_err); end
        total++; if (cur_half !== 8'd4) begin bad++; $display("FAIL err_cur_half got=%0d exp=4", cur_half); end
        at_cyc(b + 18);
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL err_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL err_event got=%0d@%0d exp=%0d@%0d", a.kind, a.cyc, e.kind, e.cyc); end
        end
    endtask

    task automatic test_stop();
        logic [31:0] b;
        ev_t e, a;
        // Stop requested during the high phase: phase runs to completion.
        do_reset();
        en = 1'b1; b = cyc + 1;
        exp_rise(b + 4); exp_q.push_back(mk(K_FALL, b + 8));
        at_cyc(b + 5);
        en = 1'b0;
        at_cyc(b + 7);
        total++; if (slow_clk !== 1'b1 || running !== 1'b1) begin bad++; $display("FAIL stop_hi_hold got=%0d/%0d exp=1/1", slow_clk, running); end
        at_cyc(b + 8);
        total++; if (slow_clk !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL stop_hi_idle got=%0d/%0d exp=0/0", slow_clk, running); end
        at_cyc(b + 20);
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL stop_hi_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL stop_hi_event got=%0d@%0d exp=%0d@%0d", a.kind, a.cyc, e.kind, e.cyc); end
        end
        // Stop requested during the low phase: immediate.
        do_reset();
        en = 1'b1; b = cyc + 1;
        exp_rise(b + 4); exp_q.push_back(mk(K_FALL, b + 8));
        at_cyc(b + 9);
        en = 1'b0;
        total++; if (running !== 1'b1) begin bad++; $display("FAIL stop_lo_pre got=%0d exp=1", running); end
        @(negedge clk);
        total++; if (slow_clk !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL stop_lo_idle got=%0d/%0d exp=0/0", slow_clk, running); end
        at_cyc(b + 20);
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL stop_lo_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL stop_lo_event got=%0d@%0d exp=%0d@%0d", a.kind, a.cyc, e.kind, e.cyc); end
        end
    endtask

    task automatic test_boundary_cfg();
        logic [31:0] b;
        ev_t e, a;
        do_reset();
        en = 1'b1; b = cyc + 1;
        exp_rise(b + 4); exp_q.push_back(mk(K_FALL, b + 8));
        exp_rise(b + 12); exp_q.push_back(mk(K_FALL, b + 16));
        exp_rise(b + 18); exp_q.push_back(mk(K_FALL, b + 20));
        exp_rise(b + 22);
        at_cyc(b + 7);
        cfg_valid = 1'b1; cfg_half = 8'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        total++; if (cur_half !== 8'd4 || cfg_ready !== 1'b0) begin bad++; $display("FAIL bnd_defer got=%0d/%0d exp=4/0", cur_half, cfg_ready); end
        at_cyc(b + 15);
        total++; if (cur_half !== 8'd4) begin bad++; $display("FAIL bnd_hold got=%0d exp=4", cur_half); end
        at_cyc(b + 16);
        total++; if (cur_half !== 8'd2) begin bad++; $display("FAIL bnd_apply got=%0d exp=2", cur_half); end
        at_cyc(b + 23);
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL bnd_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL bnd_event got=%0d@%0d exp=%0d@%0d", a.kind, a.cyc, e.kind, e.cyc); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] b;
        ev_t e, a;
        do_reset();
        en = 1'b1; b = cyc + 1;
        at_cyc(b + 4);
        cfg_valid = 1'b1; cfg_half = 8'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        at_cyc(b + 6);
        total++; if (slow_clk !== 1'b1 || cfg_ready !== 1'b0) begin bad++; $display("FAIL ar_pre got=%0d/%0d exp=1/0", slow_clk, cfg_ready); end
        #2 rst = 1'b1;
        #1;
        total++; if (slow_clk !== 1'b0 || tick !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL ar_outs got=%0d/%0d/%0d exp=0/0/0", slow_clk, tick, running); end
        total++; if (cur_half !== 8'd4 || cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin bad++; $display("FAIL ar_cfg got=%0d/%0d/%0d exp=4/1/0", cur_half, cfg_ready, cfg_err); end
        @(negedge clk);
        do_reset();
        en = 1'b1; b = cyc + 1;
        exp_rise(b + 4); exp_q.push_back(mk(K_FALL, b + 8));
        exp_rise(b + 12); exp_q.push_back(mk(K_FALL, b + 16));
        at_cyc(b + 18);
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL ar_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL ar_event got=%0d@%0d exp=%0d@%0d", a.kind, a.cyc, e.kind, e.cyc); end
        end
    endtask

    task automatic test_cfg_limits();
        logic [31:0] b;
        ev_t e, a;
        do_reset();
        cfg_valid = 1'b1; cfg_half = 8'hFF;
        @(negedge clk);
        total++; if (cur_half !== 8'hFF || cfg_err !== 1'b0) begin bad++; $display("FAIL max_cfg got=%0d/%0d exp=255/0", cur_half, cfg_err); end
        cfg_half = 8'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        total++; if (cur_half !== 8'hFF || cfg_err !== 1'b1) begin bad++; $display("FAIL zero_cfg got=%0d/%0d exp=255/1", cur_half, cfg_err); end
        en = 1'b1; b = cyc + 1;
        exp_rise(b + 255);
        at_cyc(b + 257);
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL max_count got=%0d exp=%0d", act_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e) begin bad++; $display("FAIL max_event got=%0d@%0d exp=%0d@%0d", a.kind, a.cyc, e.kind, e.cyc); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_run();
        test_reconfig();
        test_illegal();
        test_stop();
        test_boundary_cfg();
        test_async_reset();
        test_cfg_limits();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
